// File: rtl/axil_msi_pkg.sv
// Shared types for the AXI4-Lite MSI writer.
// AXIL_MSI_TIMEOUT_EN adds the FLUSH state used after a B-response timeout.
package axil_msi_pkg;

`ifdef AXIL_MSI_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_RESP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_e;
`endif

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_msi_rr_arb.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module axil_msi_rr_arb #(
    parameter int unsigned NR_REQ = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [NR_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic [NR_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o
);

    always_comb begin
        int unsigned pos;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 1; i <= NR_REQ; i++) begin
            pos = (32'(last_i) + i) % NR_REQ;
            if (!found && req_i[IDX_W'(pos)]) begin
                found               = 1'b1;
                gnt_o[IDX_W'(pos)]  = 1'b1;
                idx_o               = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/axil_msi_writer.sv
// Shares one AXI4-Lite write port among NR_REQ MSI requesters, round-robin.
// Define AXIL_MSI_TIMEOUT_EN to add a B-response timeout with a FLUSH state.
module axil_msi_writer
    import axil_msi_pkg::*;
#(
    parameter int unsigned NR_REQ         = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         i_clk,
    input  logic                         ni_rst,
    input  logic [NR_REQ-1:0]            i_req_valid,
    input  logic [NR_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NR_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NR_REQ-1:0]            o_req_ready,
    output logic [NR_REQ-1:0]            o_done_valid,
    output logic                         o_done_err,
    output logic                         o_busy,
    output logic [ADDR_WIDTH-1:0]        o_aw_addr,
    output logic                         o_aw_valid,
    input  logic                         i_aw_ready,
    output logic [DATA_WIDTH-1:0]        o_w_data,
    output logic [DATA_WIDTH/8-1:0]      o_w_strb,
    output logic                         o_w_valid,
    input  logic                         i_w_ready,
    input  logic [1:0]                   i_b_resp,
    input  logic                         i_b_valid,
    output logic                         o_b_ready,
    output logic                         o_ar_valid,
    output logic [ADDR_WIDTH-1:0]        o_ar_addr,
    output logic                         o_r_ready
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        last_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic                    aw_valid_q;
    logic                    w_valid_q;
    logic                    b_ready_q;
    logic [NR_REQ-1:0]       done_valid_q;
    logic                    done_err_q;

    logic [NR_REQ-1:0]       arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    aw_fin;
    logic                    w_fin;
    logic [ADDR_WIDTH-1:0]   req_addr [NR_REQ];
    logic [DATA_WIDTH-1:0]   req_data [NR_REQ];

`ifdef AXIL_MSI_TIMEOUT_EN
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]          cnt_q;
`else
    logic                      unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        for (int k = 0; k < NR_REQ; k++) begin
            req_addr[k] = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            req_data[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    axil_msi_rr_arb #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req_i  (i_req_valid),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // Grant is only offered while idle; held low while reset is asserted.
    assign o_req_ready = (state_q == ST_IDLE && ni_rst) ? arb_gnt : '0;

    assign aw_fin = !aw_valid_q || i_aw_ready;
    assign w_fin  = !w_valid_q  || i_w_ready;

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            last_q       <= IDX_W'(NR_REQ - 1);
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            done_valid_q <= '0;
            done_err_q   <= 1'b0;
`ifdef AXIL_MSI_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            done_valid_q <= '0;
            done_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        aw_addr_q  <= req_addr[arb_idx];
                        w_data_q   <= req_data[arb_idx];
                        idx_q      <= arb_idx;
                        last_q     <= arb_idx;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                // AW and W complete independently; RESP once both are done.
                ST_SEND: begin
                    if (i_aw_ready) aw_valid_q <= 1'b0;
                    if (i_w_ready)  w_valid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        b_ready_q <= 1'b1;
                        state_q   <= ST_RESP;
`ifdef AXIL_MSI_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                ST_RESP: begin
                    if (i_b_valid) begin
                        done_valid_q <= NR_REQ'(1) << idx_q;
                        done_err_q   <= (i_b_resp != AXI_RESP_OKAY);
                        b_ready_q    <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
`ifdef AXIL_MSI_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        done_valid_q <= NR_REQ'(1) << idx_q;
                        done_err_q   <= 1'b1;
                        state_q      <= ST_FLUSH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
`ifdef AXIL_MSI_TIMEOUT_EN
                // Swallow the late B silently; the requester was already told.
                ST_FLUSH: begin
                    if (i_b_valid) begin
                        b_ready_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_done_valid = done_valid_q;
    assign o_done_err   = done_err_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_aw_addr    = aw_addr_q;
    assign o_aw_valid   = aw_valid_q;
    assign o_w_data     = w_data_q;
    assign o_w_strb     = '1;
    assign o_w_valid    = w_valid_q;
    assign o_b_ready    = b_ready_q;
    assign o_ar_valid   = 1'b0;
    assign o_ar_addr    = '0;
    assign o_r_ready    = 1'b0;

endmodule

// File: tb/tb_axil_msi_writer.sv
// Scoreboard bench for axil_msi_writer: stimulus pushes expectations, monitors pop and compare.
module tb_axil_msi_writer;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      o_req_ready, o_done_valid;
    logic              o_done_err, o_busy;
    logic [AW-1:0]     o_aw_addr, o_ar_addr;
    logic              o_aw_valid, o_w_valid, o_b_ready, o_ar_valid, o_r_ready;
    logic [DW-1:0]     o_w_data;
    logic [DW/8-1:0]   o_w_strb;
    logic              aw_ready, w_ready, b_valid;
    logic [1:0]        b_resp;

    int  aw_delay = 0, w_delay = 0;
    bit  b_hold   = 1'b0;
    int  cyc      = 0;
    int  n_vec    = 0;
    int  n_miss   = 0;

    typedef struct {
        logic [N-1:0] oh;
        logic         err;
        int           lat;
        int           gcyc;
    } done_t;

    logic [AW-1:0] exp_aw[$];
    logic [DW-1:0] exp_w[$];
    done_t         exp_done[$];

    axil_msi_writer #(
        .NR_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .ni_rst(rst_n),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ready(o_req_ready), .o_done_valid(o_done_valid), .o_done_err(o_done_err),
        .o_busy(o_busy),
        .o_aw_addr(o_aw_addr), .o_aw_valid(o_aw_valid), .i_aw_ready(aw_ready),
        .o_w_data(o_w_data), .o_w_strb(o_w_strb), .o_w_valid(o_w_valid), .i_w_ready(w_ready),
        .i_b_resp(b_resp), .i_b_valid(b_valid), .o_b_ready(o_b_ready),
        .o_ar_valid(o_ar_valid), .o_ar_addr(o_ar_addr), .o_r_ready(o_r_ready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int k);
        return 32'h2800_0000 + 32'(k) * 32'h1000;
    endfunction

    function automatic logic [DW-1:0] data_of(input int k, input int n);
        return 32'h100 * 32'(k + 1) + 32'(n);
    endfunction

    // AW slave: ready after aw_delay cycles of valid
    initial begin
        int cnt;
        aw_ready = 1'b0; cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (o_aw_valid && !aw_ready) begin
                if (cnt >= aw_delay) aw_ready = 1'b1; else cnt++;
            end else begin
                aw_ready = 1'b0; cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        w_ready = 1'b0; cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (o_w_valid && !w_ready) begin
                if (cnt >= w_delay) w_ready = 1'b1; else cnt++;
            end else begin
                w_ready = 1'b0; cnt = 0;
            end
        end
    end

    initial begin
        b_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (o_b_ready && !b_valid && !b_hold) b_valid = 1'b1;
            else b_valid = 1'b0;
        end
    end

    // Monitor: every handshake / done pulse consumes one expectation
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_aw_valid && aw_ready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 64'(o_aw_addr), 64'hDEAD);
                else check("aw_addr", 64'(o_aw_addr), 64'(exp_aw.pop_front()));
            end
            if (rst_n && o_w_valid && w_ready) begin
                check("w_strb", 64'(o_w_strb), 64'hF);
                if (exp_w.size() == 0) check("w_unexpected", 64'(o_w_data), 64'hDEAD);
                else check("w_data", 64'(o_w_data), 64'(exp_w.pop_front()));
            end
            if (o_done_valid != '0) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 64'(o_done_valid), 64'h0);
                end else begin
                    e = exp_done.pop_front();
                    check("done_oh", 64'(o_done_valid), 64'(e.oh));
                    check("done_err", 64'(o_done_err), 64'(e.err));
                    if (e.lat > 0) check("done_latency", 64'(cyc - e.gcyc), 64'(e.lat));
                end
            end
        end
    end

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 200 && !idle; n++) begin
            @(negedge clk);
            if (!o_busy) idle = 1'b1;
        end
        check("idle_reached", 64'(idle), 64'h1);
    endtask

    task automatic issue(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] r, input logic err, input int lat);
        bit    got;
        done_t e;
        exp_aw.push_back(a);
        exp_w.push_back(d);
        b_resp = r;
        @(posedge clk); #1;
        req_valid[k] = 1'b1;
        req_addr[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (o_req_ready != '0) begin
                got = 1'b1;
                e.gcyc = cyc;
                check("ready_onehot", 64'(o_req_ready), 64'(4'b0001 << k));
            end
        end
        check("granted", 64'(got), 64'h1);
        e.oh = 4'b0001 << k; e.err = err; e.lat = lat;
        if (got) exp_done.push_back(e);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        wait_idle();
    endtask

    // Hold several requesters; requester k is re-armed until it has had rk grants
    task automatic run_multi(input int unsigned r0, r1, r2, r3);
        int unsigned  rem [N];
        int unsigned  cnt [N];
        logic [N-1:0] g;
        bit           fin;
        rem = '{r0, r1, r2, r3};
        cnt = '{default: 0};
        b_resp = 2'b00;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            if (rem[k] > 0) begin
                req_valid[k] = 1'b1;
                req_addr[k*AW +: AW] = addr_of(k);
                req_data[k*DW +: DW] = data_of(k, 0);
            end
        end
        fin = 1'b0;
        for (int n = 0; n < 100 && !fin; n++) begin
            @(negedge clk);
            g = o_req_ready;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (g[k] && rem[k] > 0) begin
                    rem[k]--; cnt[k]++;
                    if (rem[k] == 0) req_valid[k] = 1'b0;
                    else req_data[k*DW +: DW] = data_of(k, int'(cnt[k]));
                end
            end
            fin = (rem[0] + rem[1] + rem[2] + rem[3] == 0);
        end
        check("multi_all_granted", 64'(fin), 64'h1);
        wait_idle();
    endtask

    task automatic push_done(input logic [N-1:0] oh);
        done_t e;
        e.oh = oh; e.err = 1'b0; e.lat = 0; e.gcyc = 0;
        exp_done.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; b_resp = 2'b00;
        #22;
        check("rst_ctrl", 64'({o_req_ready, o_done_valid, o_done_err, o_busy, o_aw_valid,
                               o_w_valid, o_b_ready, o_ar_valid, o_r_ready}), 64'h0);
        check("rst_aw_addr", 64'(o_aw_addr), 64'h0);
        check("rst_w_data", 64'(o_w_data), 64'h0);
        check("ar_addr_tied", 64'(o_ar_addr), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single zero-wait write
        issue(2, 32'h2800_0000, 32'h0000_0005, 2'b00, 1'b0, 3);

        // Error responses: SLVERR, DECERR and EXOKAY all flag an error
        issue(1, 32'h2800_1004, 32'h0000_000A, 2'b10, 1'b1, 3);
        issue(3, 32'h2800_3008, 32'h0000_07FF, 2'b11, 1'b1, 3);
        issue(0, 32'h2800_000C, 32'h0000_0001, 2'b01, 1'b1, 3);

        // Split handshakes: AW 3 cycles late, W immediate
        aw_delay = 3; w_delay = 0;
        fork
            issue(0, 32'h2800_0010, 32'h0000_0011, 2'b00, 1'b0, 6);
            begin
                s = 1'b0;
                for (int n = 0; n < 20 && !s; n++) begin
                    @(negedge clk);
                    if (o_aw_valid) s = 1'b1;
                end
                @(negedge clk);
                check("split_send2", 64'({o_aw_valid, o_w_valid, o_b_ready}), 64'b100);
                repeat (2) @(negedge clk);
                check("split_send4", 64'({o_aw_valid, o_w_valid, o_b_ready}), 64'b100);
                @(negedge clk);
                check("split_resp", 64'({o_aw_valid, o_w_valid, o_b_ready}), 64'b001);
            end
        join
        // Opposite order: W 2 cycles late
        aw_delay = 0; w_delay = 2;
        issue(3, 32'h2800_3010, 32'hCAFE_0003, 2'b00, 1'b0, 5);
        w_delay = 0;

        // Fairness from reset: 0,1,2,3,0
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_aw.push_back(32'h2800_0000); exp_w.push_back(32'h0000_0100);
        exp_aw.push_back(32'h2800_1000); exp_w.push_back(32'h0000_0200);
        exp_aw.push_back(32'h2800_2000); exp_w.push_back(32'h0000_0300);
        exp_aw.push_back(32'h2800_3000); exp_w.push_back(32'h0000_0400);
        exp_aw.push_back(32'h2800_0000); exp_w.push_back(32'h0000_0101);
        push_done(4'b0001); push_done(4'b0010); push_done(4'b0100);
        push_done(4'b1000); push_done(4'b0001);
        run_multi(2, 1, 1, 1);

        // Reset during SEND abandons the write; requester 0 has priority after
        aw_delay = 5; w_delay = 5;
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        req_addr[1*AW +: AW] = 32'h2800_1FF0;
        req_data[1*DW +: DW] = 32'h0000_0BAD;
        s = 1'b0;
        for (int n = 0; n < 20 && !s; n++) begin
            @(negedge clk);
            if (o_req_ready[1]) s = 1'b1;
        end
        @(posedge clk); #1 req_valid[1] = 1'b0;
        #2 check("midsend_aw_valid", 64'({o_aw_valid, o_w_valid, o_busy}), 64'b111);
        rst_n = 1'b0; req_valid[0] = 1'b1;
        #1;
        check("async_rst_ctrl", 64'({o_req_ready, o_done_valid, o_done_err, o_busy, o_aw_valid,
                                     o_w_valid, o_b_ready}), 64'h0);
        check("async_rst_aw_addr", 64'(o_aw_addr), 64'h0);
        check("async_rst_w_data", 64'(o_w_data), 64'h0);
        @(posedge clk); #1;
        req_valid = '0; aw_delay = 0; w_delay = 0;
        rst_n = 1'b1;
        exp_aw.push_back(32'h2800_0000); exp_w.push_back(32'h0000_0100);
        exp_aw.push_back(32'h2800_2000); exp_w.push_back(32'h0000_0300);
        push_done(4'b0001); push_done(4'b0100);
        run_multi(1, 0, 1, 0);

`ifdef AXIL_MSI_TIMEOUT_EN
        // No B: error done after 8 RESP cycles, busy until the late B
        b_hold = 1'b1;
        fork
            issue(2, 32'h2800_2020, 32'h0000_0022, 2'b00, 1'b1, 10);
            begin
                repeat (14) @(negedge clk);
                check("flush_busy", 64'({o_busy, o_b_ready}), 64'b11);
                b_hold = 1'b0;
            end
        join
        check("flush_idle", 64'(o_busy), 64'h0);
`endif

        repeat (5) @(negedge clk);
        check("aw_queue_empty", 64'(exp_aw.size()), 64'h0);
        check("w_queue_empty", 64'(exp_w.size()), 64'h0);
        check("done_queue_empty", 64'(exp_done.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
